switch_debounce: RTL
====================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning the number of switch lines conditioned.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable clocks required to accept a new level (10 ms at 50 MHz); legal range 2..2^24.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(DEBOUNCE_CYCLES), meaning the per-line counter width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port sw_raw, input, WIDTH bits, asynchronous bouncing board switch levels.
REQ-007 The block SHALL have port switches, output, WIDTH bits, debounced registered levels that drive the memory's switch read port at 0xC000_0000.
REQ-008 The block SHALL have port sw_rise, output, WIDTH bits, one-clock pulse per line when its debounced level goes 0->1.
REQ-009 The block SHALL have port sw_fall, output, WIDTH bits, one-clock pulse per line when its debounced level goes 1->0.
REQ-010 The block SHALL have port changed, output, 1 bit, registered OR of all sw_rise and sw_fall bits, asserted in the same cycle as those bits.

Function
REQ-011 Each line SHALL pass through a two-flop synchronizer (sync1, sync2); no logic SHALL read sw_raw except sync1.
REQ-012 Each line SHALL own an independent CNT_W-bit counter cnt[i] and a stable bit; switches[i] SHALL equal stable[i].
REQ-013 Per line, each clock: if sync2==stable, cnt SHALL load 0 and stable SHALL hold.
REQ-014 Per line, each clock: if sync2!=stable and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment by 1 and stable SHALL hold.
REQ-015 Per line, each clock: if sync2!=stable and cnt==DEBOUNCE_CYCLES-1, stable SHALL load sync2 and cnt SHALL load 0.
REQ-016 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 A raw level held constant SHALL appear on switches on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples it into sync1.
REQ-018 Any return of sync2 to the stable value before acceptance SHALL discard accumulated count, so bounces shorter than DEBOUNCE_CYCLES clocks never reach switches.
REQ-019 sw_rise[i]/sw_fall[i] SHALL assert on the same edge that stable[i] updates, for exactly one clock, and SHALL never both be 1.
REQ-020 Lines changing on the same edge SHALL each produce their own pulse; changed SHALL be a single 1-clock pulse for that edge.
REQ-021 switches SHALL change at most once per DEBOUNCE_CYCLES clocks per line.

Reset
REQ-022 While reset_n=0, sync1, sync2, stable, cnt, sw_rise, sw_fall and changed SHALL all be 0, asynchronously, independent of clk.
REQ-023 Reset asserted mid-count SHALL abort the count; after release, a line with sw_raw=1 SHALL require the full REQ-017 latency before switches[i]=1.
REQ-024 Deassertion SHALL not itself generate any sw_rise, sw_fall or changed pulse.

Verification (DEBOUNCE_CYCLES=4, WIDTH=10)
REQ-025 Reset, sw_raw=10'h000, release, 20 clocks -> switches=10'h000, no pulses.
REQ-026 sw_raw 10'h000->10'h001 held -> switches=10'h001 on the 6th edge after change; sw_rise=10'h001 and changed=1 for that one clock only.
REQ-027 Bounce on sw_raw[3]: 1 for 3 clocks, 0 for 1, 1 for 3, 0 held -> switches[3] stays 0, no pulses.
REQ-028 From 10'h000, sw_raw=10'h3FF on one edge -> all lines update on the same edge, sw_rise=10'h3FF, a single changed pulse; then 10'h000 -> sw_fall=10'h3FF.
REQ-029 With sw_raw=10'h200, assert reset_n=0 at count 2 for 1 clock -> switches=0 during reset, and switches[9]=1 exactly 6 edges after release.
REQ-030 Assertion checks over random bounce stimulus: cnt<=3, sw_rise&sw_fall==0, changed==|(sw_rise|sw_fall).

Source files
------------

// File: rtl/switch_debounce.sv
// Switch conditioner: 2-flop synchronizer plus per-line stability counter with edge pulses.
// Latency: a held raw level reaches switches on the (DEBOUNCE_CYCLES+2)th clock edge.
// Backpressure: none; a free-running sampler with no handshake.
module switch_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  // Terminal count: a mismatch seen while the counter sits here is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0]            stable;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;

  logic [WIDTH-1:0]            stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_d;
  logic                        changed_d;

  // Two-flop synchronizer; sync1 is the only reader of the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-line next state: count consecutive mismatches, restart on any agreement,
  // accept the new level once the count has reached its terminal value.
  always_comb begin
    stable_d = stable;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_d[i] = sync2[i];
          rise_d[i]   = sync2[i];
          fall_d[i]   = ~sync2[i];
        end else begin
          cnt_d[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // Debounce state and registered edge pulses, all updating on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable  <= '0;
      cnt     <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      changed <= 1'b0;
    end else begin
      stable  <= stable_d;
      cnt     <= cnt_d;
      sw_rise <= rise_d;
      sw_fall <= fall_d;
      changed <= changed_d;
    end
  end

  assign switches = stable;

endmodule
